// File: rtl/if_fetch_ctrl.sv
`timescale 1ns/1ps
// if_fetch_ctrl: instruction-fetch sequencer.
// Owns the PC and arbitrates the single-port instruction RAM between the
// fetch path and a program-loader write port. Handles stall and redirect.
// Optional macro IF_ARB_FAIR_EN: bounds loader bursts to LD_BURST writes,
// then forces one fetch cycle before the loader gets the RAM back.
module if_fetch_ctrl #(
  parameter int          RAM_AW   = 10,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = 32'd4,
  parameter int          LD_BURST = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [31:0]       br_target,
  input  logic              ld_req,
  input  logic [31:0]       ld_addr,
  input  logic [31:0]       ld_data,
  output logic              ld_ack,
  output logic              ram_ena,
  output logic              ram_wena,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_indata,
  input  logic [31:0]       ram_outdata,
  output logic [31:0]       if_pc,
  output logic [31:0]       if_npc,
  output logic [31:0]       if_instr,
  output logic              if_valid
);

  typedef enum logic [1:0] {FETCH, LOAD, RESUME} state_t;

  state_t      state, state_nx;
  logic [31:0] pc, pc_nx, if_pc_nx;
  logic        if_valid_nx;
  logic        fair_blk;
  logic        do_wr;

`ifdef IF_ARB_FAIR_EN
  localparam int CW = $clog2(LD_BURST + 1);
  logic [CW-1:0] burst_cnt, burst_cnt_nx;
`endif

  // Address bits the RAM never sees; collected so they read as intentionally unused.
  logic unused_ok;
  assign unused_ok = ^{ld_addr[31:RAM_AW+2], ld_addr[1:0], 1'(LD_BURST)};

  assign if_instr = ram_outdata;
  assign if_npc   = if_pc + PC_INC;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_nx;
  end

  // PC, presented PC/valid and (optionally) the loader burst counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      if_pc    <= RESET_PC;
      if_valid <= 1'b0;
`ifdef IF_ARB_FAIR_EN
      burst_cnt <= '0;
`endif
    end else begin
      pc       <= pc_nx;
      if_pc    <= if_pc_nx;
      if_valid <= if_valid_nx;
`ifdef IF_ARB_FAIR_EN
      burst_cnt <= burst_cnt_nx;
`endif
    end
  end

  // Arbitration, next state and RAM port drive. RAM controls and ld_ack are
  // forced to zero while reset is asserted so a mid-load reset drops the
  // write immediately rather than at the next edge.
  always_comb begin
    state_nx    = state;
    pc_nx       = pc;
    if_pc_nx    = if_pc;
    if_valid_nx = if_valid;
    ram_ena     = 1'b0;
    ram_wena    = 1'b0;
    ram_addr    = pc[RAM_AW+1:2];
    ram_indata  = '0;
    ld_ack      = 1'b0;
    fair_blk    = 1'b0;
`ifdef IF_ARB_FAIR_EN
    fair_blk     = (burst_cnt == CW'(LD_BURST));
`endif
    do_wr = ld_req && !fair_blk;
`ifdef IF_ARB_FAIR_EN
    // Count consecutive writes; any non-write cycle restarts the burst.
    burst_cnt_nx = do_wr ? burst_cnt + 1'b1 : '0;
`endif

    if (do_wr) begin
      // Loader wins the RAM; any fetch in flight is squashed.
      ram_ena     = 1'b1;
      ram_wena    = 1'b1;
      ram_addr    = ld_addr[RAM_AW+1:2];
      ram_indata  = ld_data;
      ld_ack      = 1'b1;
      if_valid_nx = 1'b0;
      state_nx    = LOAD;
    end else if (state == LOAD && !ld_req) begin
      // Loader done: RAM idle this cycle, refetch next.
      state_nx = RESUME;
    end else begin
      // FETCH, RESUME, or the forced fetch slot of a fair-arbitrated burst.
      state_nx = FETCH;
      if (!br_taken && !stall) begin
        ram_ena     = 1'b1;
        if_pc_nx    = pc;
        if_valid_nx = 1'b1;
        pc_nx       = pc + PC_INC;
      end
    end

    // Redirect overrides stall and squashes the wrong-path fetch.
    if (br_taken) begin
      pc_nx       = br_target & ~32'd3;
      if_valid_nx = 1'b0;
    end

    if (!rst_n) begin
      ram_ena    = 1'b0;
      ram_wena   = 1'b0;
      ram_addr   = '0;
      ram_indata = '0;
      ld_ack     = 1'b0;
    end
  end

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
- Sequences the instruction-fetch stage: owns the PC register and issues word reads to the single-port instruction RAM.
- Arbitrates that RAM between fetch and a program-loader write port.
- Handles pipeline stall and branch redirect, and presents instruction/PC/valid to the decode stage.
- Sits between the IF datapath (PC adder, instruction RAM with ena/wena/indata/outdata) and the ID stage/loader.

Parameters:
- RAM_AW, 10, instruction RAM word-address width; ram_addr = pc[RAM_AW+1:2]
- RESET_PC, 32'h0000_0000, PC value after reset
- PC_INC, 4, byte increment per sequential fetch
- LD_BURST, 8, maximum consecutive loader writes (used only with IF_ARB_FAIR_EN)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  ID stage cannot accept; hold fetch
- br_taken  in  1  redirect request, single-cycle pulse
- br_target  in  32  redirect byte address; bits [1:0] ignored (forced 0)
- ld_req  in  1  loader requests a RAM write this cycle
- ld_addr  in  32  loader byte address; bits [1:0] ignored
- ld_data  in  32  loader write data
- ld_ack  out  1  write performed this cycle
- ram_ena  out  1  RAM enable
- ram_wena  out  1  RAM write enable
- ram_addr  out  RAM_AW  RAM word address
- ram_indata  out  32  RAM write data
- ram_outdata  in  32  RAM read data: 1-cycle synchronous latency, held while ram_ena=0
- if_pc  out  32  PC of the instruction on if_instr
- if_npc  out  32  if_pc + PC_INC, mod 2^32
- if_instr  out  32  fetched instruction; equals ram_outdata
- if_valid  out  1  if_instr/if_pc are valid for ID

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, if_pc=RESET_PC, state=FETCH.
  - if_valid=0, ld_ack=0.
  - ram_ena=0, ram_wena=0, ram_addr=0, ram_indata=0.
  - Reset mid-LOAD aborts immediately; no ack is issued.
- States:
  - FETCH: normal operation.
  - LOAD: loader owns the RAM.
  - RESUME: one cycle, refetch after LOAD.
- FETCH, stall=0, no branch, no ld_req:
  - ram_ena=1, ram_wena=0, ram_addr=pc word.
  - Next edge: if_pc<=pc, if_valid<=1, pc<=pc+PC_INC (wraps 32'hFFFF_FFFC -> 0).
- Latency: address issued in cycle N; if_instr/if_pc/if_valid are valid in cycle N+1. Throughput is 1 per cycle.
- FETCH, stall=1:
  - ram_ena=0; pc, if_pc and if_valid hold.
  - if_instr holds via the RAM output hold.
  - On release, the next address is issued the same cycle.
- br_taken=1 (any state):
  - Next edge: pc<=br_target&~3, if_valid<=0, squashing the wrong-path fetch in flight.
  - Branch has priority over stall.
  - br_taken in LOAD updates pc only; the fetch occurs in RESUME.
- ld_req=1 in FETCH: takes priority over fetch this cycle, same as LOAD.
- LOAD, per ld_req cycle:
  - ram_ena=1, ram_wena=1, ram_addr=ld_addr word, ram_indata=ld_data, ld_ack=1 (combinational, same cycle).
  - if_valid<=0; pc holds.
  - The transition into LOAD also squashes any in-flight fetch.
- LOAD with ld_req=0: ram_ena=0, next state RESUME.
- RESUME:
  - Behaves as FETCH of the current pc (stall/branch rules apply). Next state FETCH.
  - ld_req in RESUME re-enters LOAD.
- Simultaneous br_taken + ld_req: write is performed, pc<=br_target, state LOAD.
- Simultaneous br_taken + stall: the redirect is taken and if_valid<=0.
- if_npc is combinational from if_pc.

Optional Feature:
- Macro: IF_ARB_FAIR_EN.
- Defined:
  - A burst counter counts consecutive LOAD writes.
  - After LD_BURST writes, ld_ack=0 and the RAM is given to one fetch cycle (RESUME-style, ram_wena=0) even if ld_req=1.
  - The counter resets on that fetch or when ld_req=0.
- Undefined: the loader holds the RAM indefinitely while ld_req=1 and no counter exists.

Test Plan:
- Reset release with RESET_PC=0, stall=0 for 5 cycles -> ram_addr 0,1,2,3,4. if_pc 0,4,8,12 appear one cycle later with if_valid=1; if_npc=if_pc+4.
- stall=1 for 3 cycles after if_pc=8 -> ram_ena=0, if_pc=8 and if_instr held. After release, if_pc=12 is presented one cycle later.
- br_taken with br_target=32'h0000_0103 while pc=16 -> next cycle if_valid=0, pc=32'h100. Following cycle if_pc=32'h100, if_valid=1.
- Loader writes 3 words (addr 0x40,0x44,0x48 with data A,B,C) -> ld_ack=1 for 3 cycles, ram_wena=1, if_valid=0. Then RESUME refetches the held pc. Afterwards, fetching 0x40 returns A.
- Start 0xFFFF_FFF8 via branch -> pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0. Assert rst_n=0 mid-LOAD -> all outputs go to reset values immediately.
- IF_ARB_FAIR_EN with LD_BURST=8 and ld_req held for 12 cycles -> ld_ack pattern is 8 ones, 1 zero (fetch issued), then 3 ones.
